// File: rtl/timer_pkg.sv
// Shared types and digit limits for the countdown timer stages
// (seconds sequencer, minute counters, display).
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] SEC_ONES_MAX = 4'd9;

endpackage

// File: rtl/tick_gen.sv
// Modulo-DIV up-counter with enable and synchronous clear; tc flags the
// enabled cycle in which the count sits at DIV-1 (it wraps on that edge).
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int unsigned W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tc = en && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_sequencer.sv
// Seconds stage of the countdown timer: 1 Hz prescaler, BCD seconds 59..00,
// minute-counter enable/load pulses and the idle/run/pause/done control FSM.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | stopped, seconds 00, waiting for start
// ST_RUN   | prescaler counting, seconds decrement on each tick
// ST_PAUSE | prescaler and seconds frozen, start resumes
// ST_DONE  | reached 00:00, seconds held, alarm LED blinking
module countdown_sequencer
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       load,
  input  logic       min_zero,
  input  logic       min_error,
  output logic       min_load,
  output logic       min_ce,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  state_t state;
  logic   tick;
  logic   blink_tc;
  logic   err_abort;
  logic   pre_clr;
  logic   last_sec;

  assign err_abort = min_error && (state == ST_RUN || state == ST_PAUSE);
  // Holding the prescaler clear throughout IDLE gives a full first second after start.
  assign pre_clr   = load || err_abort || (state == ST_IDLE);
  assign last_sec  = (sec_tens == 4'd0) && (sec_ones == 4'd1);

  tick_gen #(.DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (state == ST_RUN),
    .clr   (pre_clr),
    .tc    (tick)
  );

  tick_gen #(.DIV(BLINK_DIV)) u_blink (
    .clk   (clk),
    .reset (reset),
    .en    (state == ST_DONE),
    .clr   (state != ST_DONE),
    .tc    (blink_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
      min_load <= 1'b0;
      min_ce   <= 1'b0;
      running  <= 1'b0;
      done     <= 1'b0;
      alarm    <= 1'b0;
    end else begin
      min_load <= load;
      min_ce   <= 1'b0;
      if (load || err_abort) begin
        state    <= ST_IDLE;
        sec_tens <= 4'd0;
        sec_ones <= 4'd0;
        running  <= 1'b0;
        done     <= 1'b0;
        alarm    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !min_error && !min_zero) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end
          ST_RUN: begin
            if (tick) begin
              if (sec_tens == 4'd0 && sec_ones == 4'd0) begin
                sec_tens <= SEC_TENS_MAX;
                sec_ones <= SEC_ONES_MAX;
                min_ce   <= 1'b1;
              end else if (sec_ones == 4'd0) begin
                sec_ones <= SEC_ONES_MAX;
                sec_tens <= sec_tens - 4'd1;
              end else begin
                sec_ones <= sec_ones - 4'd1;
              end
            end
            // Reaching 00:00 outranks a coincident pause request.
            if (tick && last_sec && min_zero) begin
              state   <= ST_DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end else if (start) begin
              state   <= ST_PAUSE;
              running <= 1'b0;
            end
          end
          ST_PAUSE: begin
            if (start) begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end
          ST_DONE: begin
            if (start) begin
              state <= ST_IDLE;
              done  <= 1'b0;
              alarm <= 1'b0;
            end else if (blink_tc) begin
              alarm <= ~alarm;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer: directed scenarios plus random stimulus,
// compared every cycle against an integer-seconds reference model.
module tb_countdown_sequencer;

  localparam int TICK  = 4;
  localparam int BLINK = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       load = 1'b0;
  logic       min_zero = 1'b0;
  logic       min_error = 1'b0;
  logic       min_load, min_ce, running, done, alarm;
  logic [3:0] sec_tens, sec_ones;

  always #5 clk = ~clk;

  countdown_sequencer #(.TICK_DIV(TICK), .BLINK_DIV(BLINK)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .load      (load),
    .min_zero  (min_zero),
    .min_error (min_error),
    .min_load  (min_load),
    .min_ce    (min_ce),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .running   (running),
    .done      (done),
    .alarm     (alarm)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;
  mode_t m_mode;
  int    m_secs;
  int    m_run_cyc;
  int    m_done_cyc;
  bit    m_load, m_ce;
  bit    g_err = 1'b0;
  bit    g_mz  = 1'b0;

  function automatic void model_reset();
    m_mode     = M_IDLE;
    m_secs     = 0;
    m_run_cyc  = 0;
    m_done_cyc = 0;
    m_load     = 1'b0;
    m_ce       = 1'b0;
  endfunction

  function automatic void model_step(input bit ld, input bit st, input bit err, input bit mz);
    bit tick;
    bit was_zero;
    m_load = ld;
    m_ce   = 1'b0;
    if (ld) begin
      m_mode    = M_IDLE;
      m_secs    = 0;
      m_run_cyc = 0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          if (st && !err && !mz) begin
            m_mode    = M_RUN;
            m_run_cyc = 0;
          end
        end
        M_RUN: begin
          if (err) begin
            m_mode    = M_IDLE;
            m_secs    = 0;
            m_run_cyc = 0;
          end else begin
            m_run_cyc++;
            tick = (m_run_cyc == TICK);
            if (tick) m_run_cyc = 0;
            was_zero = (m_secs == 0);
            if (tick) begin
              if (was_zero) begin
                m_secs = 59;
                m_ce   = 1'b1;
              end else begin
                m_secs--;
              end
            end
            if (tick && !was_zero && m_secs == 0 && mz) begin
              m_mode     = M_DONE;
              m_done_cyc = 0;
            end else if (st) begin
              m_mode = M_PAUSE;
            end
          end
        end
        M_PAUSE: begin
          if (err) begin
            m_mode    = M_IDLE;
            m_secs    = 0;
            m_run_cyc = 0;
          end else if (st) begin
            m_mode = M_RUN;
          end
        end
        M_DONE: begin
          if (st) m_mode = M_IDLE;
          else m_done_cyc++;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    bit exp_alarm;
    exp_alarm = (m_mode == M_DONE) && (((m_done_cyc / BLINK) % 2) == 1);
    check({tag, "_secs"}, {24'd0, sec_tens, sec_ones},
          {24'd0, 4'(m_secs / 10), 4'(m_secs % 10)});
    check({tag, "_flags"}, {27'd0, min_load, min_ce, running, done, alarm},
          {27'd0, m_load, m_ce, m_mode == M_RUN, m_mode == M_DONE, exp_alarm});
  endtask

  // Inputs are applied 1 time unit after a rising edge and sampled 1 unit after the next.
  task automatic cyc(input bit ld, input bit st);
    load      = ld;
    start     = st;
    min_error = g_err;
    min_zero  = g_mz;
    model_step(ld, st, g_err, g_mz);
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  task automatic async_reset();
    load  = 1'b0;
    start = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_async");
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_outputs("rst_held");
  endtask

  initial begin
    int guard;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("rst_init");
    reset = 1'b1;
    repeat (2) cyc(0, 0);

    // Reset asserted mid-RUN in the cycle min_ce is high
    cyc(1, 0);
    cyc(0, 1);
    repeat (4) cyc(0, 0);
    check("ce_before_rst", {31'd0, min_ce}, 32'd1);
    async_reset();
    repeat (2) cyc(0, 0);

    // Load then start: 59 with min_ce, then 58, 57
    cyc(1, 0);
    cyc(0, 1);
    repeat (12) cyc(0, 0);

    // Count down to 10, then finish with min_zero set
    guard = 0;
    while (m_secs != 10 && guard < 400) begin
      cyc(0, 0);
      guard++;
    end
    check("reach_10", {24'd0, sec_tens, sec_ones}, 32'h10);
    g_mz = 1'b1;
    repeat (60) cyc(0, 0);
    check("done_hold", {31'd0, done}, 32'd1);
    cyc(0, 1);
    cyc(0, 1);
    cyc(0, 0);
    check("mz_start_ignored", {31'd0, running}, 32'd0);
    g_mz = 1'b0;

    // Pause part-way through a tick period
    cyc(1, 0);
    cyc(0, 1);
    repeat (2) cyc(0, 0);
    cyc(0, 1);
    repeat (20) cyc(0, 0);
    cyc(0, 1);
    repeat (10) cyc(0, 0);

    // Start and load together during RUN
    cyc(1, 0);
    cyc(0, 1);
    repeat (5) cyc(0, 0);
    cyc(1, 1);
    repeat (3) cyc(0, 0);

    // min_error in RUN and in PAUSE
    cyc(0, 1);
    repeat (6) cyc(0, 0);
    g_err = 1'b1;
    cyc(0, 0);
    cyc(0, 1);
    repeat (3) cyc(0, 0);
    g_err = 1'b0;
    cyc(0, 1);
    repeat (5) cyc(0, 0);
    cyc(0, 1);
    g_err = 1'b1;
    cyc(0, 0);
    g_err = 1'b0;
    cyc(0, 0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      g_err = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 49) == 0) g_mz = ~g_mz;
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 24) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
